// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one external adder among NUM_REQ
// requesters and returns the tagged sum, carry-out and signed overflow.
module adder_share_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADD_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_a,
    input  logic [NUM_REQ*WIDTH-1:0]           req_b,
    input  logic [NUM_REQ-1:0]                 req_cin,
    output logic [WIDTH-1:0]                   add_a,
    output logic [WIDTH-1:0]                   add_b,
    output logic                               add_cin,
    input  logic [WIDTH-1:0]                   add_sum,
    input  logic                               add_cout,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
    output logic [WIDTH-1:0]                   rsp_sum,
    output logic                               rsp_cout,
    output logic                               rsp_ovf,
    output logic                               busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic               found;
    logic [IDW-1:0]     gnt_idx;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               cin_sel;
    logic [NUM_REQ-1:0] req_ready_c;

    // First valid requester scanning upward from the rotating priority pointer.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin : scan
            int unsigned idx;
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel   = req_a[i*WIDTH +: WIDTH];
                b_sel   = req_b[i*WIDTH +: WIDTH];
                cin_sel = req_cin[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        req_ready_c = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c = NUM_REQ'(1) << gnt_idx;
                    a_d         = a_sel;
                    b_d         = b_sel;
                    cin_d       = cin_sel;
                    id_d        = gnt_idx;
                    cnt_d       = CW'(ADD_CYCLES - 1);
                    ptr_d       = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_d     = ADD;
                end
            end
            ADD: begin
                if (cnt_q == '0) begin
                    sum_d   = add_sum;
                    cout_d  = add_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Grant is combinational; keep it quiet while reset is asserted.
    assign req_ready = req_ready_c & {NUM_REQ{rst_n}};
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: vector table, scoreboard, contention,
// backpressure and reset-abort sequences on two instances (settle 1 and 3).
module tb_adder_share_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n1, rst_n3;
    logic [N-1:0]   req_valid1, req_ready1, req_cin1;
    logic [N*W-1:0] req_a1, req_b1;
    logic [W-1:0]   add_a1, add_b1, add_sum1, rsp_sum1;
    logic           add_cin1, add_cout1, rsp_valid1, rsp_ready1, rsp_cout1, rsp_ovf1, busy1;
    logic [1:0]     rsp_id1;

    logic [N-1:0]   req_valid3, req_ready3, req_cin3;
    logic [N*W-1:0] req_a3, req_b3;
    logic [W-1:0]   add_a3, add_b3, add_sum3, rsp_sum3;
    logic           add_cin3, add_cout3, rsp_valid3, rsp_ready3, rsp_cout3, rsp_ovf3, busy3;
    logic [1:0]     rsp_id3;

    // Behavioural models of the shared adder.
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {32'd0, add_cin1};
    assign {add_cout3, add_sum3} = {1'b0, add_a3} + {1'b0, add_b3} + {32'd0, add_cin3};

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_cin(req_cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
        .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1), .rsp_ovf(rsp_ovf1), .busy(busy1)
    );

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
        .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_sum(add_sum3), .add_cout(add_cout3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3), .rsp_ovf(rsp_ovf3), .busy(busy3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    rsp_t sb_q[$];
    int   gnt_log[$];

    // Scoreboard on dut1: expected result pushed at grant, popped at response handshake.
    always @(negedge clk) begin : sb_mon
        int          g;
        logic [31:0] a, b;
        logic        c;
        logic [32:0] tot;
        rsp_t        e;
        rsp_t        r;
        if (rst_n1) begin
            if (req_ready1 != '0) begin
                check("gnt_onehot", 64'($countones(req_ready1)), 64'd1);
                g = 0;
                for (int i = 0; i < int'(N); i++) if (req_ready1[i]) g = i;
                a   = req_a1[g*W +: W];
                b   = req_b1[g*W +: W];
                c   = req_cin1[g];
                tot = {1'b0, a} + {1'b0, b} + {32'd0, c};
                e.id   = 2'(g);
                e.sum  = tot[31:0];
                e.cout = tot[32];
                e.ovf  = (a[31] == b[31]) && (tot[31] != a[31]);
                sb_q.push_back(e);
                gnt_log.push_back(g);
            end
            if (busy1) check("no_ready_when_busy", 64'(req_ready1), 64'd0);
            if (rsp_valid1 && rsp_ready1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    r = sb_q.pop_front();
                    check("sb_id",   64'(rsp_id1),   64'(r.id));
                    check("sb_sum",  64'(rsp_sum1),  64'(r.sum));
                    check("sb_cout", 64'(rsp_cout1), 64'(r.cout));
                    check("sb_ovf",  64'(rsp_ovf1),  64'(r.ovf));
                end
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic apply_vec(input vec_t v);
        int lat;
        @(posedge clk); #1;
        req_a1[v.id*W +: W] = v.a;
        req_b1[v.id*W +: W] = v.b;
        req_cin1[v.id]      = v.cin;
        req_valid1          = 4'b0001 << v.id;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready1 != '0) break;
        end
        check("vec_grant", 64'(req_ready1), 64'(4'b0001 << v.id));
        @(posedge clk); #1;
        req_valid1 = '0;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid1) break;
        end
        check("vec_latency", 64'(lat), 64'd2);
        check("vec_id",   64'(rsp_id1),   64'(v.id));
        check("vec_sum",  64'(rsp_sum1),  64'(v.sum));
        check("vec_cout", 64'(rsp_cout1), 64'(v.cout));
        check("vec_ovf",  64'(rsp_ovf1),  64'(v.ovf));
    endtask

    task automatic drain1();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0 && !busy1) break;
        end
        check("drain_idle", 64'(busy1), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        logic [31:0] bp_sum;

        vecs[0] = '{1, 32'd100,        32'hFFFFFF38, 1'b0, 32'hFFFFFF9C, 1'b0, 1'b0};
        vecs[1] = '{2, 32'h7FFFFFFF,   32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{3, 32'h80000000,   32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{0, 32'hFFFFFFCE,   32'hFFFFFF9C, 1'b1, 32'hFFFFFF6B, 1'b1, 1'b0};
        vecs[4] = '{3, 32'hFFFFFFFF,   32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{0, 32'h00000000,   32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[6] = '{2, 32'h80000000,   32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7] = '{1, 32'h12345678,   32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};

        rst_n1 = 1'b0; rst_n3 = 1'b0;
        req_a1 = '0; req_b1 = '0; req_cin1 = '0; req_valid1 = '0; rsp_ready1 = 1'b1;
        req_a3 = '0; req_b3 = '0; req_cin3 = '0; req_valid3 = '0; rsp_ready3 = 1'b1;

        // Contention operands, all requesters valid while still in reset.
        for (int i = 0; i < int'(N); i++) begin
            req_a1[i*W +: W] = 32'h11111111 * i;
            req_b1[i*W +: W] = 32'h01000000 + i;
            req_cin1[i]      = i[0];
        end
        req_valid1 = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready1), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid1), 64'd0);
        check("rst_busy",      64'(busy1),      64'd0);
        check("rst_rsp",       64'({rsp_id1, rsp_sum1, rsp_cout1, rsp_ovf1}), 64'd0);
        check("rst_add",       64'({add_a1, add_b1, add_cin1}), 64'd0);
        rst_n3 = 1'b1;

        gnt_log.delete();
        rst_n1 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (gnt_log.size() >= 5) break;
        end
        @(posedge clk); #1;
        req_valid1 = '0;
        check("cont_count", 64'(gnt_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < gnt_log.size()) check("cont_order", 64'(gnt_log[k]), 64'(k % 4));
        end
        drain1();

        foreach (vecs[k]) apply_vec(vecs[k]);
        drain1();

        // Backpressure: result held while requester 3 waits, grant the cycle after handshake.
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
        req_a1[2*W +: W] = 32'd5;
        req_b1[2*W +: W] = 32'd7;
        req_cin1[2]      = 1'b0;
        req_a1[3*W +: W] = 32'hAAAA0000;
        req_b1[3*W +: W] = 32'h00005555;
        req_cin1[3]      = 1'b1;
        req_valid1       = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready1 != '0) break;
        end
        check("bp_grant", 64'(req_ready1), 64'h4);
        @(posedge clk); #1;
        req_valid1 = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid1) break;
        end
        bp_sum = rsp_sum1;
        check("bp_sum", 64'(bp_sum), 64'd12);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid_hold", 64'(rsp_valid1), 64'd1);
            check("bp_rsp_hold",   64'({rsp_id1, rsp_sum1, rsp_cout1, rsp_ovf1}), 64'({2'd2, 32'd12, 1'b0, 1'b0}));
            check("bp_no_grant",   64'(req_ready1), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready1 = 1'b1;
        @(negedge clk);
        check("bp_no_grant_hs", 64'(req_ready1), 64'd0);
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready1), 64'h8);
        @(posedge clk); #1;
        req_valid1 = '0;
        drain1();

        // Reset abort on the 3-cycle instance: move the pointer first.
        @(posedge clk); #1;
        req_a3[0*W +: W] = 32'd10; req_b3[0*W +: W] = 32'd20;
        req_a3[1*W +: W] = 32'd1;  req_b3[1*W +: W] = 32'd2;
        req_valid3 = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready3 != '0) break;
        end
        check("r3_grant0", 64'(req_ready3), 64'h1);
        @(posedge clk); #1;
        req_valid3 = '0;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid3) break;
        end
        check("r3_latency", 64'(lat), 64'd4);
        check("r3_sum0", 64'({rsp_id3, rsp_sum3}), 64'({2'd0, 32'd30}));

        @(posedge clk); #1;
        req_valid3 = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready3 != '0) break;
        end
        check("r3_grant1", 64'(req_ready3), 64'h2);
        @(posedge clk); #1;
        req_valid3 = '0;
        @(posedge clk); #1;
        check("r3_busy_add2", 64'(busy3), 64'd1);
        rst_n3 = 1'b0;
        req_valid3 = 4'hF;
        #1;
        check("r3_rst_ready", 64'(req_ready3), 64'd0);
        check("r3_rst_flags", 64'({rsp_valid3, busy3}), 64'd0);
        check("r3_rst_rsp",   64'({rsp_id3, rsp_sum3, rsp_cout3, rsp_ovf3}), 64'd0);
        check("r3_rst_add",   64'({add_a3, add_b3, add_cin3}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n3 = 1'b1;
        @(negedge clk);
        check("r3_prio_after_rst", 64'(req_ready3), 64'h1);
        check("r3_no_stale_rsp",   64'(rsp_valid3), 64'd0);
        @(posedge clk); #1;
        req_valid3 = '0;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid3) break;
        end
        check("r3_latency2", 64'(lat), 64'd4);
        check("r3_first_rsp", 64'({rsp_id3, rsp_sum3}), 64'({2'd0, 32'd30}));

        repeat (3) @(posedge clk);
        check("sb_empty_end", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer sharing one 32-bit carry-bypass adder among NUM_REQ requesters. It accepts one operand set at a time through a valid/ready handshake, drives the external adder for a fixed number of settle cycles, and captures sum, carry-out and signed overflow. It returns the tagged result through a valid/ready response port. It sits between requesting units and the single adder instance in the arithmetic datapath.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 32: operand/sum width; must match the adder.
- ADD_CYCLES, 1: adder settle cycles per operation (≥1; 0 illegal).
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- add_a, add_b  out  WIDTH  operands to adder.
- add_cin  out  1  carry-in to adder.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- rsp_ovf  out  1  signed overflow flag.
- busy  out  1  high in ADD or RESP.

## Operation
- FSM states: IDLE, ADD, RESP. Reset state is IDLE.
- IDLE: if any req_valid is high, grant the highest-priority valid requester g. req_ready[g] is combinational and is raised in the same cycle. Latch req_a/req_b/req_cin of g into the operand registers and g into the id register. Load the settle counter with ADD_CYCLES-1, then go to ADD. With no valid requester, stay in IDLE.
- Round-robin priority: after a grant to g, priority starts at (g+1) mod NUM_REQ. After reset, requester 0 has highest priority.
- req_ready is low in ADD and RESP. Requesters must hold their operands stable while valid and not ready. Dropping valid before grant is legal: that requester is simply not granted.
- ADD: add_a/add_b/add_cin are driven straight from the operand registers, which hold their last value in every state. Decrement the counter each cycle. When the counter is 0, capture add_sum and add_cout into rsp_sum/rsp_cout, compute rsp_ovf, and go to RESP.
- Overflow rule: rsp_ovf = (a[W-1]==b[W-1]) && (add_sum[W-1]!=a[W-1]), carry-in included. Carry-out and overflow are independent.
- RESP: rsp_valid is high. rsp_* and rsp_id hold stable until the cycle in which rsp_valid && rsp_ready. The FSM then goes to IDLE on the next edge. No new grant is made in the handshake cycle.
- Reset values: req_ready 0, rsp_valid 0, busy 0. rsp_sum/rsp_cout/rsp_ovf/rsp_id 0. add_a/add_b/add_cin 0. Priority pointer 0.
- Async reset mid-ADD or mid-RESP aborts the operation. The in-flight result is discarded and no response is produced.

## Timing
- Grant accepted in cycle T, when the FSM is in IDLE and req_valid[g]&&req_ready[g].
- ADD occupies cycles T+1 .. T+ADD_CYCLES. add_* are valid from T+1.
- Result is captured at the end of cycle T+ADD_CYCLES. rsp_valid rises at T+ADD_CYCLES+1.
- Response handshake in cycle R gives IDLE at R+1. The earliest next grant is at R+1.
- Minimum issue interval: ADD_CYCLES+2 cycles.
- busy equals (state!=IDLE) and is registered with the state.

## Test plan
- Single request: requester 1 with A=100, B=-200 (0xFFFFFF38), cin=0, rsp_ready=1, ADD_CYCLES=1. Required: rsp_valid 2 cycles after the grant, rsp_id=1, rsp_sum=0xFFFFFF9C, rsp_cout=0, rsp_ovf=0.
- Overflow cases:
  - A=0x7FFFFFFF, B=1, cin=0 gives rsp_sum=0x80000000, rsp_ovf=1, rsp_cout=0.
  - A=0x80000000, B=0xFFFFFFFF gives rsp_sum=0x7FFFFFFF, rsp_ovf=1, rsp_cout=1.
- Carry-in: A=-50, B=-100, cin=1 gives rsp_sum=-149 (0xFFFFFF6B), rsp_cout=1, rsp_ovf=0.
- Contention: all 4 req_valid held high from reset. Required: grant order 0,1,2,3,0. Exactly one req_ready bit per grant. Each rsp_id matches the grant order.
- Backpressure: rsp_ready low for 5 cycles during RESP. Required: rsp_valid and rsp_* stay stable, no req_ready is raised, and the next grant comes one cycle after rsp_ready rises.
- Reset mid-ADD with ADD_CYCLES=3: assert rst_n=0 in the second ADD cycle. Required: all outputs go to 0 immediately, no response appears, and after release requester 0 has priority again.
